// File: rtl/pipe_adder.sv
// Pipelined ripple-chunk adder/subtractor: chunk k of the sum is formed in stage k.
// Optional build macro PIPE_ADDER_SAT_EN clamps the sum on signed overflow.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Per-stage slot: operands travel with the partial sum so later stages can
  // finish the upper chunks.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             cy;
  } stage_t;

`ifdef PIPE_ADDER_SAT_EN
  function automatic logic [WIDTH-1:0] sat_fn(input logic signed [WIDTH-1:0] s,
                                              input logic ov);
    logic [WIDTH-1:0] r;
    r = s;
    if (ov) r = s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    return r;
  endfunction
`endif

  logic           advance;
  stage_t         src   [STAGES];
  stage_t         stg_d [STAGES];
  stage_t         stg_p [STAGES];
  logic [CHUNK:0] part;
  logic           ovf_d;
  logic           ovf_p;

  assign advance  = out_ready || !out_valid;
  assign in_ready = rst_n && advance;

  always_comb begin
    src[0].vld = in_valid && in_ready;
    src[0].opa = a;
    src[0].opb = sub ? ~b : b;
    src[0].acc = '0;
    src[0].cy  = sub | c_in;
    for (int k = 1; k < STAGES; k++) src[k] = stg_p[k-1];

    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, src[k].opa[k*CHUNK +: CHUNK]}
           + {1'b0, src[k].opb[k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, src[k].cy};
      stg_d[k] = src[k];
      stg_d[k].acc[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      stg_d[k].cy = part[CHUNK];
    end

    // Carry into the MSB is recovered from the MSB sum bit.
    ovf_d = src[LAST].opa[WIDTH-1] ^ src[LAST].opb[WIDTH-1]
          ^ stg_d[LAST].acc[WIDTH-1] ^ stg_d[LAST].cy;
`ifdef PIPE_ADDER_SAT_EN
    stg_d[LAST].acc = sat_fn(stg_d[LAST].acc, ovf_d);
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k boundary
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       stg_p[k] <= '0;
      else if (advance) stg_p[k] <= stg_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_p <= 1'b0;
    else if (advance) ovf_p <= ovf_d;
  end

  assign out_valid = stg_p[LAST].vld;
  assign sum       = stg_p[LAST].acc;
  assign c_out     = stg_p[LAST].cy;
  assign ovf       = ovf_p;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4) with a reference model
// computed from integer arithmetic.
module tb_pipe_adder;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic          c_in, sub;
  logic          out_valid, out_ready;
  logic [W-1:0]  sum;
  logic          c_out, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t exp_q[$];

  pipe_adder #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci, input logic sb);
    int   sa, sv, t, u;
    res_t r;
    sa = int'($signed(aa));
    sv = int'($signed(bb));
    t  = sb ? sa - sv : sa + sv + int'(ci);
    u  = sb ? int'(aa) + 65536 - int'(bb) : int'(aa) + int'(bb) + int'(ci);
    r.c = (u >= 65536);
    r.o = (t > 32767) || (t < -32768);
    r.s = t[W-1:0];
`ifdef PIPE_ADDER_SAT_EN
    if (r.o) r.s = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
    return r;
  endfunction

  // One cycle: drive at negedge, report whether input/output transfers occur at the next posedge.
  task automatic drive(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ci, input logic sb, input logic rdy,
                       output logic acc, output logic fire);
    @(negedge clk);
    in_valid = v; a = aa; b = bb; c_in = ci; sub = sb; out_ready = rdy;
    #1;
    fire = out_valid && out_ready;
    acc  = in_valid && in_ready;
    if (acc) exp_q.push_back(model(aa, bb, ci, sb));
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b sum=%h c_out=%b ovf=%b, need 0 0 0000 0 0",
               out_valid, in_ready, sum, c_out, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    typedef struct packed {
      logic [W-1:0] a; logic [W-1:0] b; logic ci; logic sb;
      logic [W-1:0] s; logic c; logic o;
    } vec_t;
    vec_t vt[5];
    logic acc, fire;
    int   lat;
    res_t m;
`ifdef PIPE_ADDER_SAT_EN
    logic [W-1:0] pos_ovf = 16'h7FFF;
`else
    logic [W-1:0] pos_ovf = 16'h8000;
`endif
    vt[0] = '{16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, pos_ovf,  1'b0, 1'b1};
    vt[3] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, 1'b1, acc, fire);
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL directed_accept[%0d]: accepted=%b need 1", i, acc);
      end
      lat = 0;
      fire = 1'b0;
      while (!fire && lat < 12) begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, fire);
        lat++;
      end
      checks++;
      if (!fire || lat != 4) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d cycles (fired=%b), need 4", i, lat, fire);
      end
      checks++;
      if (sum !== vt[i].s || c_out !== vt[i].c || ovf !== vt[i].o) begin
        errors++;
        $display("FAIL directed_result[%0d]: sum=%h c_out=%b ovf=%b, need %h %b %b",
                 i, sum, c_out, ovf, vt[i].s, vt[i].c, vt[i].o);
      end
      if (exp_q.size() > 0) m = exp_q.pop_front();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa[8], ob[8];
    logic         oc[8], os[8];
    logic         acc, fire, rdy;
    int           idx, got, cyc;
    res_t         held, e;
    for (int i = 0; i < 8; i++) begin
      oa[i] = W'($urandom); ob[i] = W'($urandom);
      oc[i] = 1'($urandom); os[i] = 1'($urandom);
    end
    idx = 0; got = 0; cyc = 0;
    held = '0;
    while (got < 8 && cyc < 60) begin
      rdy = !(cyc >= 5 && cyc <= 7);
      if (idx < 8) drive(1'b1, oa[idx], ob[idx], oc[idx], os[idx], rdy, acc, fire);
      else         drive(1'b0, '0, '0, 1'b0, 1'b0, rdy, acc, fire);
      if (acc) idx++;
      if (!rdy) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_stall_ready[cyc %0d]: in_ready=%b out_valid=%b, need 0 1",
                   cyc, in_ready, out_valid);
        end
        if (cyc == 5) held = '{sum, c_out, ovf};
        else begin
          checks++;
          if ({sum, c_out, ovf} !== held) begin
            errors++;
            $display("FAIL b2b_hold[cyc %0d]: sum=%h c_out=%b ovf=%b, held %h %b %b",
                     cyc, sum, c_out, ovf, held.s, held.c, held.o);
          end
        end
      end
      if (fire) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected result sum=%h", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, c_out, ovf} !== e) begin
            errors++;
            $display("FAIL b2b_result[%0d]: sum=%h c_out=%b ovf=%b, need %h %b %b",
                     got, sum, c_out, ovf, e.s, e.c, e.o);
          end
        end
      end
      cyc++;
    end
    checks++;
    if (got != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d results with %0d pending, need 8 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic acc, fire;
    int   got;
    res_t e;
    got = 0;
    for (int cyc = 0; cyc < 330; cyc++) begin
      if (cyc < 300)
        drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom_range(0, 9) < 7), acc, fire);
      else
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, fire);
      if (fire) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL random_extra: unexpected result sum=%h", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, c_out, ovf} !== e) begin
            errors++;
            $display("FAIL random_result[%0d]: sum=%h c_out=%b ovf=%b, need %h %b %b",
                     got, sum, c_out, ovf, e.s, e.c, e.o);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: %0d results pending, out_valid=%b, need 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic acc, fire;
    int   lat;
    drive(1'b1, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b1, acc, fire);
    drive(1'b1, 16'h2222, 16'h1111, 1'b1, 1'b0, 1'b1, acc, fire);
    drive(1'b1, 16'h4000, 16'h0010, 1'b0, 1'b1, 1'b1, acc, fire);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc, fire);
    @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h1335) begin
      errors++;
      $display("FAIL midreset_pre: out_valid=%b sum=%h, need 1 1335", out_valid, sum);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: out_valid=%b in_ready=%b sum=%h c_out=%b ovf=%b, need 0 0 0000 0 0",
               out_valid, in_ready, sum, c_out, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, fire);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_ghost[%0d]: out_valid=%b sum=%h, need 0", i, out_valid, sum);
      end
    end
    drive(1'b1, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b1, acc, fire);
    lat = 0;
    fire = 1'b0;
    while (!fire && lat < 12) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc, fire);
      lat++;
    end
    checks++;
    if (!fire || lat != 4 || sum !== 16'h0008 || c_out !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: fired=%b lat=%0d sum=%h c_out=%b ovf=%b, need 1 4 0008 0 0",
               fire, lat, sum, c_out, ovf);
    end
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits, minimum 4.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES; CHUNK = WIDTH/STAGES.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operands a, b, c_in and sub are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1: pipe accepts an operation this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A, two's complement.
REQ-008 SHALL have port b, input, WIDTH: operand B, two's complement.
REQ-009 SHALL have port c_in, input, 1: carry-in for add; ignored when sub=1.
REQ-010 SHALL have port sub, input, 1: 1 = compute a-b, 0 = compute a+b+c_in.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port c_out, output, 1: unsigned carry out of the MSB.
REQ-015 SHALL have port ovf, output, 1: signed overflow.

Function
REQ-016 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-017 SHALL define advance = out_ready || !out_valid; in_ready SHALL equal advance; all stages SHALL shift together on advance and hold otherwise.
REQ-018 SHALL add chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) in stage k, using the carry registered from stage k-1; untouched upper chunks and operand bits SHALL be carried along in stage registers.
REQ-019 SHALL present the result STAGES cycles after acceptance when no stall occurs; throughput SHALL be one operation per cycle.
REQ-020 SHALL, when sub=1, use ~b as operand B and carry-in 1.
REQ-021 SHALL set c_out to the carry out of bit WIDTH-1, and ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-022 SHALL propagate one valid bit per stage; bubbles (in_valid=0) SHALL flow through as invalid slots.
REQ-023 SHALL hold sum, c_out and ovf stable while out_valid && !out_ready.
REQ-024 SHALL preserve operation order, with no loss or duplication under any out_ready pattern.
REQ-025 SHALL leave in_valid=1 with in_ready=0 without effect; the operation is accepted on the first cycle in_ready=1.

Reset
REQ-026 SHALL, on rst_n low, immediately clear all stage valid bits and data registers to 0: out_valid=0, sum=0, c_out=0, ovf=0.
REQ-027 SHALL drive in_ready=0 while rst_n is low, and in_ready=1 on the first cycle after release.
REQ-028 SHALL discard in-flight operations on reset mid-operation; none SHALL emerge after release.

Configuration
REQ-029 SHALL, with PIPE_ADDER_SAT_EN defined, clamp sum on ovf=1 to 2^(WIDTH-1)-1 for positive overflow and -2^(WIDTH-1) for negative overflow, with ovf and c_out still reported unchanged.
REQ-030 SHALL, with PIPE_ADDER_SAT_EN undefined, output the wrapped two's-complement sum; latency SHALL be identical in both builds.

Verification (WIDTH=16, STAGES=4)
REQ-031 SHALL cover a=0x0005, b=0x0003, c_in=0, sub=0, out_ready=1 -> sum=0x0008, c_out=0, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-032 SHALL cover a=0xFFFF, b=0x0001 -> sum=0x0000, c_out=1, ovf=0 (carry crosses all chunks); and a=0x7FFF, b=0x0001 -> ovf=1, sum=0x8000 (0x7FFF with PIPE_ADDER_SAT_EN).
REQ-033 SHALL cover sub=1, a=0x0003, b=0x0005, c_in=1 -> sum=0xFFFE, c_out=0, ovf=0 (c_in ignored).
REQ-034 SHALL cover 8 back-to-back operations with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, outputs held, all 8 results correct and in order.
REQ-035 SHALL cover 3 operations in flight, then rst_n low for 1 cycle -> out_valid=0 immediately, no result emerges, next operation correct after 4 cycles.
